// File: rtl/alu_operand_sequencer_if.sv
// Operand/result bus between the operand sequencer and the 8-bit combinational ALU.
interface alu_operand_sequencer_if;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [2:0] alu_ctrl;
    logic [7:0] alu_result;
    logic       alu_zero;
    logic       alu_carry;

    modport master (
        output alu_a, alu_b, alu_ctrl,
        input  alu_result, alu_zero, alu_carry
    );

    modport slave (
        input  alu_a, alu_b, alu_ctrl,
        output alu_result, alu_zero, alu_carry
    );
endinterface

// File: rtl/alu_operand_sequencer.sv
// Captures A, B and opcode from the switches on debounced ENTER presses, then
// registers the ALU result and flags. CLEAR aborts entry without touching data.
//   state   | meaning
//   LOAD_A  | waiting for operand A
//   LOAD_B  | waiting for operand B
//   LOAD_OP | waiting for opcode (sw[2:0])
//   EXEC    | one-cycle ALU settle, capture on next edge
//   SHOW    | result held, ENTER restarts entry
module alu_operand_sequencer #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int CNT_W           = 20
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [7:0]                     sw,
    input  logic                           btn_enter,
    input  logic                           btn_clr,
    alu_operand_sequencer_if.master        alu,
    output logic [7:0]                     res_q,
    output logic                           zero_q,
    output logic                           carry_q,
    output logic                           done,
    output logic [2:0]                     state_o
);
    typedef enum logic [2:0] {
        LOAD_A  = 3'd0,
        LOAD_B  = 3'd1,
        LOAD_OP = 3'd2,
        EXEC    = 3'd3,
        SHOW    = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    // Bit 0 is ENTER, bit 1 is CLEAR; both share one synchronizer/debounce pipeline.
    logic [1:0]       btn_raw;
    logic [1:0]       sync1, sync2, db, db_d;
    logic [CNT_W-1:0] cnt [2];
    logic             enter_p, clr_p;

    state_t state, state_nxt;
    logic   ld_a, ld_b, ld_op, cap;

    assign btn_raw = {btn_clr, btn_enter};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1  <= '0;
            sync2  <= '0;
            db     <= '0;
            db_d   <= '0;
            cnt[0] <= '0;
            cnt[1] <= '0;
        end else begin
            sync1 <= btn_raw;
            sync2 <= sync1;
            db_d  <= db;
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] != db[i]) begin
                    if (cnt[i] == CNT_MAX) begin
                        db[i]  <= ~db[i];
                        cnt[i] <= '0;
                    end else begin
                        cnt[i] <= cnt[i] + CNT_W'(1);
                    end
                end else begin
                    cnt[i] <= '0;
                end
            end
        end
    end

    assign enter_p = db[0] & ~db_d[0];
    assign clr_p   = db[1] & ~db_d[1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= LOAD_A;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            LOAD_A:  if (enter_p) state_nxt = LOAD_B;
            LOAD_B:  if (enter_p) state_nxt = LOAD_OP;
            LOAD_OP: if (enter_p) state_nxt = EXEC;
            EXEC:    state_nxt = SHOW;
            SHOW:    if (enter_p) state_nxt = LOAD_A;
            default: state_nxt = LOAD_A;
        endcase
        if (clr_p) state_nxt = LOAD_A;
    end

    // CLEAR has priority over ENTER, so every load/capture enable is gated by it.
    always_comb begin
        ld_a  = 1'b0;
        ld_b  = 1'b0;
        ld_op = 1'b0;
        cap   = 1'b0;
        case (state)
            LOAD_A:  ld_a  = enter_p & ~clr_p;
            LOAD_B:  ld_b  = enter_p & ~clr_p;
            LOAD_OP: ld_op = enter_p & ~clr_p;
            EXEC:    cap   = ~clr_p;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu.alu_a    <= '0;
            alu.alu_b    <= '0;
            alu.alu_ctrl <= '0;
            res_q        <= '0;
            zero_q       <= 1'b0;
            carry_q      <= 1'b0;
            done         <= 1'b0;
        end else begin
            done <= cap;
            if (ld_a)  alu.alu_a    <= sw;
            if (ld_b)  alu.alu_b    <= sw;
            if (ld_op) alu.alu_ctrl <= sw[2:0];
            if (cap) begin
                res_q   <= alu.alu_result;
                zero_q  <= alu.alu_zero;
                carry_q <= alu.alu_carry;
            end
        end
    end

    assign state_o = state;
endmodule

// File: tb/tb_alu_operand_sequencer.sv
// Bench for alu_operand_sequencer: expected captures are queued at stimulus time
// and a monitor compares them whenever done pulses.
module tb_alu_operand_sequencer;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] sw = 8'h00;
    logic       btn_enter = 1'b0;
    logic       btn_clr = 1'b0;
    logic [7:0] res_q;
    logic       zero_q, carry_q, done;
    logic [2:0] state_o;
    logic [8:0] r9;

    int n_total = 0;
    int n_pass  = 0;

    typedef struct packed {
        logic [7:0] res;
        logic       z;
        logic       c;
    } exp_t;
    exp_t exp_q[$];

    alu_operand_sequencer_if bus ();

    alu_operand_sequencer #(.DEBOUNCE_CYCLES(4), .CNT_W(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .sw        (sw),
        .btn_enter (btn_enter),
        .btn_clr   (btn_clr),
        .alu       (bus),
        .res_q     (res_q),
        .zero_q    (zero_q),
        .carry_q   (carry_q),
        .done      (done),
        .state_o   (state_o)
    );

    always #5 clk = ~clk;

    // Behavioural ALU: carry is the carry-out for ADD and the borrow for SUB.
    always_comb begin
        r9 = 9'h000;
        case (bus.alu_ctrl)
            3'b000:  r9 = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
            3'b001:  r9 = {1'b0, bus.alu_a} - {1'b0, bus.alu_b};
            3'b010:  r9 = {1'b0, bus.alu_a & bus.alu_b};
            3'b011:  r9 = {1'b0, bus.alu_a | bus.alu_b};
            3'b100:  r9 = {1'b0, bus.alu_a ^ bus.alu_b};
            default: r9 = {1'b0, ~bus.alu_a};
        endcase
    end
    assign bus.alu_result = r9[7:0];
    assign bus.alu_carry  = r9[8];
    assign bus.alu_zero   = (r9[7:0] == 8'h00);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_total++;
        if (act === expv) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, expv);
    endtask

    task automatic press(input logic e, input logic c, input int hold);
        @(negedge clk);
        btn_enter = e;
        btn_clr   = c;
        repeat (hold) @(negedge clk);
        btn_enter = 1'b0;
        btn_clr   = 1'b0;
        repeat (10) @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (!rst && done === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("done_unexpected", {31'd0, done}, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("res_q",   {24'd0, res_q},   {24'd0, e.res});
                chk("zero_q",  {31'd0, zero_q},  {31'd0, e.z});
                chk("carry_q", {31'd0, carry_q}, {31'd0, e.c});
            end
        end
    end

    initial begin
        bit found;

        #1;
        chk("rst_state", {29'd0, state_o}, 32'd0);
        chk("rst_alu_a", {24'd0, bus.alu_a}, 32'd0);
        chk("rst_res_q", {24'd0, res_q}, 32'd0);
        chk("rst_done",  {31'd0, done}, 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // ADD 0x3C + 0xC4 = 0x100
        sw = 8'h3C; press(1, 0, 8);
        chk("add_state_b", {29'd0, state_o}, 32'd1);
        chk("add_alu_a", {24'd0, bus.alu_a}, 32'h3C);
        sw = 8'hC4; press(1, 0, 8);
        chk("add_state_op", {29'd0, state_o}, 32'd2);
        chk("add_alu_b", {24'd0, bus.alu_b}, 32'hC4);
        exp_q.push_back('{res: 8'h00, z: 1'b1, c: 1'b1});
        sw = 8'h00; press(1, 0, 8);
        chk("add_alu_ctrl", {29'd0, bus.alu_ctrl}, 32'd0);
        chk("add_state_show", {29'd0, state_o}, 32'd4);
        press(1, 0, 8);
        chk("show_to_load_a", {29'd0, state_o}, 32'd0);

        // SUB 0x05 - 0x07 = 0xFE with borrow
        sw = 8'h05; press(1, 0, 8);
        sw = 8'h07; press(1, 0, 8);
        exp_q.push_back('{res: 8'hFE, z: 1'b0, c: 1'b1});
        sw = 8'h01; press(1, 0, 8);
        chk("sub_state_show", {29'd0, state_o}, 32'd4);
        press(1, 0, 8);
        chk("sub_state_a", {29'd0, state_o}, 32'd0);
        chk("sub_alu_a_kept", {24'd0, bus.alu_a}, 32'h05);

        // Bounce: 2 high, 1 low, 2 high never reaches 4 stable samples
        sw = 8'h11;
        @(negedge clk); btn_enter = 1'b1;
        repeat (2) @(negedge clk); btn_enter = 1'b0;
        @(negedge clk); btn_enter = 1'b1;
        repeat (2) @(negedge clk); btn_enter = 1'b0;
        repeat (12) @(negedge clk);
        chk("bounce_state", {29'd0, state_o}, 32'd0);
        chk("bounce_alu_a", {24'd0, bus.alu_a}, 32'h05);
        press(1, 0, 10);
        chk("hold10_state", {29'd0, state_o}, 32'd1);
        chk("hold10_alu_a", {24'd0, bus.alu_a}, 32'h11);

        // Clear in LOAD_OP, then clear and enter together
        sw = 8'h22; press(1, 0, 8);
        chk("clr_setup", {29'd0, state_o}, 32'd2);
        sw = 8'h06; press(0, 1, 8);
        chk("clr_state", {29'd0, state_o}, 32'd0);
        chk("clr_alu_ctrl", {29'd0, bus.alu_ctrl}, 32'd1);
        sw = 8'h33; press(1, 0, 8);
        sw = 8'h44; press(1, 0, 8);
        chk("clr2_setup", {29'd0, state_o}, 32'd2);
        sw = 8'h06; press(1, 1, 8);
        chk("clr_enter_state", {29'd0, state_o}, 32'd0);
        chk("clr_enter_alu_ctrl", {29'd0, bus.alu_ctrl}, 32'd1);
        chk("clr_res_kept", {24'd0, res_q}, 32'hFE);

        // Long press in SHOW gives one transition and no load
        sw = 8'h80; press(1, 0, 8);
        sw = 8'h80; press(1, 0, 8);
        exp_q.push_back('{res: 8'h00, z: 1'b1, c: 1'b1});
        sw = 8'h00; press(1, 0, 8);
        chk("long_setup", {29'd0, state_o}, 32'd4);
        sw = 8'h55; press(1, 0, 50);
        chk("long_state", {29'd0, state_o}, 32'd0);
        chk("long_alu_a", {24'd0, bus.alu_a}, 32'h80);
        press(1, 0, 8);
        chk("long_next_state", {29'd0, state_o}, 32'd1);
        chk("long_next_alu_a", {24'd0, bus.alu_a}, 32'h55);

        // Reset during EXEC
        sw = 8'h66; press(1, 0, 8);
        sw = 8'h02;
        found = 1'b0;
        @(negedge clk); btn_enter = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (state_o == 3'd3) begin
                found = 1'b1;
                break;
            end
        end
        chk("reach_exec", {31'd0, found}, 32'd1);
        if (found) begin
            rst = 1'b1;
            #1;
            chk("rstx_state", {29'd0, state_o}, 32'd0);
            chk("rstx_alu_a", {24'd0, bus.alu_a}, 32'd0);
            chk("rstx_alu_b", {24'd0, bus.alu_b}, 32'd0);
            chk("rstx_alu_ctrl", {29'd0, bus.alu_ctrl}, 32'd0);
            chk("rstx_res", {24'd0, res_q}, 32'd0);
            chk("rstx_flags", {30'd0, zero_q, carry_q}, 32'd0);
            chk("rstx_done", {31'd0, done}, 32'd0);
        end
        btn_enter = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        chk("post_rst_state", {29'd0, state_o}, 32'd0);
        chk("post_rst_res", {24'd0, res_q}, 32'd0);

        chk("pending_captures", exp_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/alu_operand_sequencer.md
Name: alu_operand_sequencer

Overview:
Upstream front-end for the 8-bit combinational ALU on the Nexys-A7 board. It captures operand A, operand B and the 3-bit opcode from the slide switches, one per debounced ENTER press, and drives them to the ALU inputs. It then registers the ALU's result, zero and carry outputs for display. A debounced CLEAR button aborts entry and restarts the sequence.

Parameters:
DEBOUNCE_CYCLES, 1_000_000, consecutive stable synchronized samples required before a button level is accepted (about 10 ms at 100 MHz); minimum 2.
CNT_W, 20, debounce counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

Ports:
clk  input  1  system clock, 100 MHz
rst  input  1  asynchronous, active-high reset
sw  input  8  slide switches; operand value, opcode taken from sw[2:0]
btn_enter  input  1  raw ENTER pushbutton, active-high, asynchronous to clk
btn_clr  input  1  raw CLEAR pushbutton, active-high, asynchronous to clk
alu_a  output  8  operand A to ALU (registered)
alu_b  output  8  operand B to ALU (registered)
alu_ctrl  output  3  opcode to ALU (registered)
alu_result  input  8  ALU result (combinational from alu_a/alu_b/alu_ctrl)
alu_zero  input  1  ALU zero flag
alu_carry  input  1  ALU carry/borrow flag
res_q  output  8  captured result
zero_q  output  1  captured zero flag
carry_q  output  1  captured carry flag
done  output  1  one-cycle pulse when res_q/zero_q/carry_q update
state_o  output  3  current FSM state code, for LEDs

Behaviour:
- Reset (asynchronous, rst=1): alu_a=0, alu_b=0, alu_ctrl=0, res_q=0, zero_q=0, carry_q=0, done=0, state=LOAD_A (code 0). Synchronizers, debounce counters and debounced levels are cleared to 0. Reset asserted at any point, including mid-EXEC, aborts immediately; no capture occurs.
- Per button: 2-flop synchronizer, then debouncer.
  - Debouncer: if the synchronized level differs from the debounced level, the counter increments; otherwise it resets to 0.
  - When the counter reaches DEBOUNCE_CYCLES-1 while the level still differs, the debounced level toggles and the counter resets.
  - Any mismatch-free cycle restarts the count, so glitches shorter than DEBOUNCE_CYCLES never toggle the level.
  - enter_p / clr_p: single-cycle pulse on each 0->1 transition of the debounced level. A held button yields exactly one pulse; release yields none.
- FSM states and codes: LOAD_A=0, LOAD_B=1, LOAD_OP=2, EXEC=3, SHOW=4.
  - LOAD_A: on enter_p, alu_a<=sw, go to LOAD_B.
  - LOAD_B: on enter_p, alu_b<=sw, go to LOAD_OP.
  - LOAD_OP: on enter_p, alu_ctrl<=sw[2:0], go to EXEC.
  - EXEC: one-cycle settle state; enter_p is ignored. On the next edge, res_q<=alu_result, zero_q<=alu_zero, carry_q<=alu_carry, done<=1, go to SHOW.
    - Latency: captured values and done appear 2 clk edges after the LOAD_OP enter_p edge.
  - SHOW: res_q, zero_q and carry_q are held. On enter_p, go to LOAD_A; alu_a, alu_b and alu_ctrl keep their values until overwritten.
- clr_p in any state returns the FSM to LOAD_A on the next edge. It does not alter alu_a, alu_b, alu_ctrl, res_q, zero_q or carry_q.
  - clr_p and enter_p in the same cycle: clr wins, no capture.
  - clr_p during EXEC: no capture, done stays 0.
- done is high for exactly one cycle per capture, and 0 otherwise.
- state_o is driven directly from the state register. Unused codes 5–7 recover to LOAD_A on the next edge.
- No combinational path from sw or the buttons to any output.

Test Plan:
(Use DEBOUNCE_CYCLES=4, CNT_W=3, and a behavioural ALU model.)
- ADD: enter sw=0x3C, 0xC4, 0x00 (op 000). Required: alu_a=0x3C, alu_b=0xC4, alu_ctrl=000; after EXEC, res_q=0x00, zero_q=1, carry_q=1, done pulses once, state_o=4.
- SUB: enter 0x05, 0x07, op 001. Required: res_q=0xFE, zero_q=0, carry_q=1. A second enter_p in SHOW gives state_o=0 with alu_a still 0x05.
- Bounce: toggle btn_enter high for 2 cycles, low for 1, high for 2, then low. Required: no enter_p, state stays LOAD_A. Then hold high for 10 cycles: exactly one enter_p, state_o=1.
- Clear: in LOAD_OP press btn_clr, and also assert enter_p and clr_p in the same cycle. Required: state_o=0 both times, alu_ctrl unchanged, done=0.
- Reset mid-EXEC: assert rst during the EXEC cycle. Required: all outputs 0 immediately (asynchronous), state_o=0, no done pulse after release.
- Long press in SHOW: hold btn_enter for 50 cycles. Required: a single transition SHOW->LOAD_A, and alu_a not loaded until the next separate press.
